// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions for the data-memory stage: instruction codes,
// stage FSM states and the icode -> memory-access decode helpers.
package y86_pkg;

  localparam logic [3:0] ICODE_HALT   = 4'h0;
  localparam logic [3:0] ICODE_NOP    = 4'h1;
  localparam logic [3:0] ICODE_RRMOVQ = 4'h2;
  localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
  localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
  localparam logic [3:0] ICODE_MRMOVQ = 4'h5;
  localparam logic [3:0] ICODE_OPQ    = 4'h6;
  localparam logic [3:0] ICODE_JXX    = 4'h7;
  localparam logic [3:0] ICODE_CALL   = 4'h8;
  localparam logic [3:0] ICODE_RET    = 4'h9;
  localparam logic [3:0] ICODE_PUSHQ  = 4'hA;
  localparam logic [3:0] ICODE_POPQ   = 4'hB;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } dmem_state_t;

  function automatic logic is_mem_read(input logic [3:0] icode);
    return (icode == ICODE_MRMOVQ) || (icode == ICODE_POPQ) || (icode == ICODE_RET);
  endfunction

  function automatic logic is_mem_write(input logic [3:0] icode);
    return (icode == ICODE_RMMOVQ) || (icode == ICODE_PUSHQ) || (icode == ICODE_CALL);
  endfunction

  // popq/ret address the stack through valB; every other access uses valE
  function automatic logic uses_valb(input logic [3:0] icode);
    return (icode == ICODE_POPQ) || (icode == ICODE_RET);
  endfunction

endpackage

// File: rtl/y86_dmem_stage_if.sv
// Request/response bundle between the SEQ core (master) and the
// data-memory stage (slave).
interface y86_dmem_stage_if #(
  parameter int DATA_W = 64
);
  logic              req_valid;
  logic              req_ready;
  logic [3:0]        icode;
  logic [DATA_W-1:0] valA;
  logic [DATA_W-1:0] valB;
  logic [DATA_W-1:0] valE;
  logic [DATA_W-1:0] valP;
  logic              resp_valid;
  logic [DATA_W-1:0] valM;
  logic              dmem_error;
  logic              busy;

  modport master (
    output req_valid, icode, valA, valB, valE, valP,
    input  req_ready, resp_valid, valM, dmem_error, busy
  );

  modport slave (
    input  req_valid, icode, valA, valB, valE, valP,
    output req_ready, resp_valid, valM, dmem_error, busy
  );
endinterface

// File: rtl/y86_dmem_array.sv
// Single-port synchronous word RAM with registered read; contents start
// zero-filled and are never cleared by reset.
module y86_dmem_array #(
  parameter int DATA_W = 64,
  parameter int DEPTH  = 256,
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              we,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    rdata <= mem[idx];
  end

endmodule

// File: rtl/y86_dmem_stage.sv
// Multi-cycle Y86-64 data-memory stage: request/response handshake with a
// fixed access latency and address-error flagging for SADR.
// Optional build macro: Y86_DMEM_ALIGN_CHECK_EN (misaligned access is an error).
module y86_dmem_stage
  import y86_pkg::*;
#(
  parameter int DATA_W  = 64,
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input logic              clk,
  input logic              rst_n,
  y86_dmem_stage_if.slave  bus
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DATA_W-1:0] DEPTH_W = DATA_W'(DEPTH);

  dmem_state_t       state;
  logic [3:0]        cnt;
  logic              respValid;
  logic [DATA_W-1:0] valMReg;
  logic              errReg;

  logic              reqRd;
  logic              reqWr;
  logic              reqErr;
  logic [IDX_W-1:0]  reqIdx;
  logic [DATA_W-1:0] reqWdata;

  logic [DATA_W-1:0] inAddr;
  logic [DATA_W-1:0] inWdata;
  logic              inRd;
  logic              inWr;
  logic              inErr;
  logic              accept;
  logic              done;
  logic              we;
  logic [IDX_W-1:0]  arrIdx;
  logic [DATA_W-1:0] rdata;

  function automatic logic addr_error(input logic [DATA_W-1:0] addr);
    logic err;
    err = (addr >> 3) >= DEPTH_W;
`ifdef Y86_DMEM_ALIGN_CHECK_EN
    err = err || (addr[2:0] != 3'b000);
`endif
    return err;
  endfunction

  assign inRd    = is_mem_read(bus.icode);
  assign inWr    = is_mem_write(bus.icode);
  assign inAddr  = uses_valb(bus.icode) ? bus.valB : bus.valE;
  assign inWdata = (bus.icode == ICODE_CALL) ? bus.valP : bus.valA;
  assign inErr   = (inRd || inWr) && addr_error(inAddr);

  assign accept = bus.req_valid && (state == S_IDLE);
  assign done   = (state == S_WAIT) && (cnt == 4'd0);

  // The array is addressed straight from the request while idle so the read
  // starts at acceptance and rdata is settled by the response edge even for
  // LATENCY=1; during WAIT it keeps reading the captured word.
  assign arrIdx = (state == S_IDLE) ? inAddr[IDX_W+2:3] : reqIdx;
  assign we     = rst_n && done && reqWr && !reqErr;

  y86_dmem_array #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_array (
    .clk   (clk),
    .we    (we),
    .idx   (arrIdx),
    .wdata (reqWdata),
    .rdata (rdata)
  );

  // Request capture at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      reqRd    <= inRd;
      reqWr    <= inWr;
      reqErr   <= inErr;
      reqIdx   <= inAddr[IDX_W+2:3];
      reqWdata <= inWdata;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 4'd0;
      respValid <= 1'b0;
      valMReg   <= '0;
      errReg    <= 1'b0;
    end else begin
      respValid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (accept) begin
            state <= S_WAIT;
            cnt   <= 4'(LATENCY - 1);
          end
        end
        S_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= S_IDLE;
            respValid <= 1'b1;
            valMReg   <= (reqRd && !reqErr) ? rdata : '0;
            errReg    <= reqErr;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready  = (state == S_IDLE);
  assign bus.busy       = (state == S_WAIT);
  assign bus.resp_valid = respValid;
  assign bus.valM       = valMReg;
  assign bus.dmem_error = errReg;

endmodule

// File: tb/tb_y86_dmem_stage.sv
// Randomized self-checking bench for y86_dmem_stage against a word-array
// reference model of the memory stage.
module tb_y86_dmem_stage;

  localparam int DATA_W  = 64;
  localparam int DEPTH   = 256;
  localparam int LATENCY = 2;

  logic clk = 1'b0;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  y86_dmem_stage_if #(.DATA_W(DATA_W)) ifc ();

  y86_dmem_stage #(
    .DATA_W  (DATA_W),
    .DEPTH   (DEPTH),
    .LATENCY (LATENCY)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (ifc)
  );

  always #5 clk = ~clk;

  logic [63:0] refMem [int];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: apply one transaction to the model memory, return valM/error.
  task automatic model(input logic [3:0] ic, input logic [63:0] a, b, e, p,
                       output logic [63:0] expM, output logic expErr);
    bit rd, wr;
    logic [63:0] addr, data;
    longint unsigned widx;
    rd = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
    wr = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
    addr = ((ic == 4'h9) || (ic == 4'hB)) ? b : e;
    data = (ic == 4'h8) ? p : a;
    expM = '0;
    expErr = 1'b0;
    if (rd || wr) begin
      widx = addr / 8;
      expErr = (widx >= DEPTH);
`ifdef Y86_DMEM_ALIGN_CHECK_EN
      if (addr % 8 != 0) expErr = 1'b1;
`endif
      if (!expErr) begin
        if (wr) refMem[int'(widx)] = data;
        else if (refMem.exists(int'(widx))) expM = refMem[int'(widx)];
      end
    end
  endtask

  task automatic doTxn(input logic [3:0] ic, input logic [63:0] a, b, e, p, input bit poke);
    logic [63:0] expM;
    logic        expErr;
    int n;
    model(ic, a, b, e, p, expM, expErr);
    @(negedge clk);
    ifc.icode = ic; ifc.valA = a; ifc.valB = b; ifc.valE = e; ifc.valP = p;
    ifc.req_valid = 1'b1;
    n = 0;
    while (!ifc.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", 64'(n < 50), 64'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    // scramble inputs after acceptance; a poke keeps a competing write pending
    ifc.icode = poke ? 4'h4 : 4'(($urandom));
    ifc.valA = {$urandom, $urandom};
    ifc.valB = {$urandom, $urandom};
    ifc.valE = poke ? 64'd40 : {$urandom, $urandom};
    ifc.valP = {$urandom, $urandom};
    ifc.req_valid = poke;
    if (poke) begin
      chk("wait_ready", 64'(ifc.req_ready), 64'd0);
      chk("wait_busy", 64'(ifc.busy), 64'd1);
    end
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (!ifc.resp_valid && n < 40);
    ifc.req_valid = 1'b0;
    chk("latency", 64'(n), 64'(LATENCY));
    chk("valM", ifc.valM, expM);
    chk("dmem_error", 64'(ifc.dmem_error), 64'(expErr));
    chk("resp_ready", 64'(ifc.req_ready), 64'd1);
    @(posedge clk);
    #1;
    chk("resp_pulse", 64'(ifc.resp_valid), 64'd0);
    chk("valM_hold", ifc.valM, expM);
    chk("err_hold", 64'(ifc.dmem_error), 64'(expErr));
  endtask

  initial begin
    logic [3:0]  ic;
    logic [63:0] addr;
    int seen;
    rst_n = 1'b0;
    ifc.req_valid = 1'b0;
    ifc.icode = '0; ifc.valA = '0; ifc.valB = '0; ifc.valE = '0; ifc.valP = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(ifc.req_ready), 64'd1);
    chk("rst_busy", 64'(ifc.busy), 64'd0);
    chk("rst_resp", 64'(ifc.resp_valid), 64'd0);
    chk("rst_valM", ifc.valM, 64'd0);
    chk("rst_err", 64'(ifc.dmem_error), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    doTxn(4'h4, 64'd4, 64'd0, 64'd8, 64'd0, 1'b0);
    doTxn(4'h5, 64'd0, 64'd0, 64'd8, 64'd0, 1'b0);
    doTxn(4'hA, 64'd8, 64'd0, 64'd16, 64'd0, 1'b0);
    doTxn(4'h8, 64'd0, 64'd0, 64'd24, 64'd20, 1'b0);
    doTxn(4'hB, 64'd0, 64'd16, 64'd0, 64'd0, 1'b0);
    doTxn(4'h9, 64'd0, 64'd24, 64'd0, 64'd0, 1'b0);
    doTxn(4'h4, 64'd99, 64'd0, 64'd2048, 64'd0, 1'b0);
    doTxn(4'h5, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0);
    doTxn(4'h4, 64'd55, 64'd0, 64'h8000_0000_0000_0008, 64'd0, 1'b0);
    doTxn(4'h5, 64'd0, 64'd0, 64'd8, 64'd0, 1'b0);
    doTxn(4'h5, 64'd0, 64'd0, 64'd12, 64'd0, 1'b0);
    doTxn(4'h6, 64'd1, 64'd2, 64'd8, 64'd3, 1'b0);
    doTxn(4'h5, 64'd0, 64'd0, 64'd40, 64'd0, 1'b1);
    doTxn(4'h5, 64'd0, 64'd0, 64'd40, 64'd0, 1'b0);

    // reset in the middle of a write: dropped, no response
    @(negedge clk);
    ifc.icode = 4'h4; ifc.valA = 64'd7; ifc.valE = 64'd32; ifc.req_valid = 1'b1;
    @(posedge clk);
    #1;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("midrst_resp", 64'(ifc.resp_valid), 64'd0);
    chk("midrst_ready", 64'(ifc.req_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (6) begin
      @(posedge clk);
      #1;
      if (ifc.resp_valid) seen++;
    end
    chk("midrst_noresp", 64'(seen), 64'd0);
    doTxn(4'h5, 64'd0, 64'd0, 64'd32, 64'd0, 1'b0);

    for (int i = 0; i < 150; i++) begin
      ic = 4'($urandom_range(0, 15));
      case ($urandom_range(0, 9))
        0:       addr = {$urandom, $urandom};
        1:       addr = 64'($urandom_range(0, 511));
        2:       addr = 64'(DEPTH * 8) + 64'($urandom_range(0, 64));
        default: addr = 64'($urandom_range(0, 15)) * 8;
      endcase
      doTxn(ic, {$urandom, $urandom}, addr, addr, {$urandom, $urandom}, ($urandom_range(0, 4) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/y86_dmem_stage.md
Name: y86_dmem_stage

Overview:
Parametrised, multi-cycle data-memory stage for the Y86-64 SEQ core.
- Replaces the single-cycle memory stage.
- Decodes icode into a read, a write or no access.
- Runs a request/response handshake with configurable access latency.
- Flags out-of-range addresses so the core can raise status SADR.
- Sits between execute (valE) and write-back (valM).

Parameters:
DATA_W, 64, word width of data and addresses (valA/valB/valE/valP/valM)
DEPTH, 256, number of DATA_W-bit words in the array
LATENCY, 2, cycles from request acceptance to response; legal range 1..15

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  synchronous active-low reset
req_valid  in  1  request present; icode/valA/valB/valE/valP valid
req_ready  out  1  stage can accept a request this cycle
icode  in  4  Y86 instruction code
valA  in  DATA_W  write data for rmmovq/pushq
valB  in  DATA_W  address for popq/ret
valE  in  DATA_W  address for rmmovq/mrmovq/pushq/call
valP  in  DATA_W  write data (return address) for call
resp_valid  out  1  one-cycle pulse: access complete, valM/dmem_error valid
valM  out  DATA_W  read data
dmem_error  out  1  address error for the completed access
busy  out  1  access in flight; drives core stall

Behaviour:
- Byte addressing with 8-byte words: word index = addr >> 3.
- Address error when index >= DEPTH, compared over the full DATA_W address.
- Decode:
  - Writes: rmmovq 4'h4 writes valA @ valE; pushq 4'hA writes valA @ valE; call 4'h8 writes valP @ valE.
  - Reads: mrmovq 4'h5 @ valE; popq 4'hB @ valB; ret 4'h9 @ valB.
  - Any other icode: no access, valM=0, dmem_error=0.
- FSM states:
  - IDLE: req_ready=1, busy=0.
  - WAIT: req_ready=0, busy=1.
- Handshake:
  - Request accepted at edge E0 when req_valid && req_ready.
  - All request fields are registered at E0; later input changes are ignored.
  - IDLE -> WAIT at E0. Counter loads LATENCY-1.
- Timing:
  - Each WAIT edge decrements the counter.
  - At edge E_LATENCY (the edge where the counter is 0): write commits, read data is sampled, valM/dmem_error are registered, resp_valid=1, state -> IDLE.
  - LATENCY=1: E_LATENCY is the edge after E0.
  - resp_valid is high exactly one cycle.
  - req_ready is high in that same cycle, so back-to-back requests have throughput of one per LATENCY+1 cycles.
- valM and dmem_error hold their last value until the next response; valM=0 for writes.
- Error access: no array write; valM=0; dmem_error=1.
- Read of a never-written in-range word: returns 0. The array is zero-filled at elaboration and is not cleared by reset.
- Read after write to the same address in a later transaction: returns the new data.
- Reset, sampled at a rising edge with rst_n=0:
  - Clears state to IDLE, counter=0, resp_valid=0, valM=0, dmem_error=0.
  - Array contents are preserved.
  - An in-flight write that has not reached E_LATENCY is dropped; no response is issued.
- req_valid while busy: ignored (req_ready=0); the requester must hold the request.

Optional Feature:
Y86_DMEM_ALIGN_CHECK_EN
- Defined: an address with addr[2:0] != 0 on any memory-accessing icode is an error. Behaviour is the same as out-of-range: no write, valM=0, dmem_error=1.
- Undefined: low three bits are ignored (word index = addr >> 3); misaligned accesses are not errors.

Decomposition:
- y86_pkg:
  - ICODE_* localparams (HALT..POPQ).
  - dmem_state_t enum {S_IDLE, S_WAIT}.
  - Helper function is_mem_read(icode) / is_mem_write(icode).
- Sub-module y86_dmem_array: single-port synchronous RAM.
  - Parameters DATA_W, DEPTH.
  - Ports clk, we, idx, wdata, rdata (registered read).

Test Plan:
- Reset: rst_n=0 for 2 cycles -> req_ready=1, busy=0, resp_valid=0, valM=0, dmem_error=0.
- LATENCY=2:
  - rmmovq icode=4, valA=4, valE=8 -> resp_valid exactly 2 edges after acceptance, dmem_error=0.
  - Then mrmovq icode=5, valE=8 -> valM=4.
- pushq icode=A, valA=8, valE=16; call icode=8, valP=20, valE=24; then popq valB=16 -> valM=8, and ret valB=24 -> valM=20.
- Out-of-range (DEPTH=256): rmmovq valE=2048, valA=99 -> dmem_error=1, valM=0.
  - Then mrmovq valE=0 -> valM unchanged from prior contents; no corruption.
- Handshake/reset: during WAIT, req_ready=0 and a second req_valid is ignored.
  - rst_n=0 one edge mid-write to valE=32, valA=7 -> no resp_valid.
  - Subsequent mrmovq valE=32 -> valM=0.
- With Y86_DMEM_ALIGN_CHECK_EN: mrmovq valE=12 -> dmem_error=1.
  - Without it: the same access reads word 1 (address 8) with dmem_error=0.
